// File: rtl/bcd_pkg.sv
// Shared definitions for the serial packed-BCD adder.
//   BCD_W / BCD_MAX : digit width and largest legal digit value
//   state_e         : FSM encoding (2'b11 is unused and falls back to idle)
//   digit_invalid() : true when a 4-bit digit is not a decimal digit
package bcd_pkg;

  localparam int unsigned BCD_W   = 4;
  localparam logic [3:0]  BCD_MAX = 4'd9;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StAdd  = 2'b01,
    StDone = 2'b10
  } state_e;

  function automatic logic digit_invalid(input logic [BCD_W-1:0] d);
    return d > BCD_MAX;
  endfunction

endpackage

// File: rtl/bcd_serial_adder_if.sv
// Request/result bundle of the serial BCD adder.
//   master : drives start, A, B, cin; observes busy, done, sum, cout, error
//   slave  : the adder side of the same signals
interface bcd_serial_adder_if #(
  parameter int unsigned NDIGITS = 4
);

  localparam int unsigned W = 4 * NDIGITS;

  logic         start;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         cin;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
  logic         error;

  modport master (
    output start, A, B, cin,
    input  busy, done, sum, cout, error
  );

  modport slave (
    input  start, A, B, cin,
    output busy, done, sum, cout, error
  );

endinterface

// File: rtl/bcd_digit_add.sv
// Single decimal digit adder with carry.
//   a, b : BCD digits (0..9)
//   ci   : decimal carry-in
//   s    : BCD sum digit
//   co   : decimal carry-out (raw sum exceeded 9)
module bcd_digit_add
  import bcd_pkg::*;
(
  input  logic [BCD_W-1:0] a,
  input  logic [BCD_W-1:0] b,
  input  logic             ci,
  output logic [BCD_W-1:0] s,
  output logic             co
);

  logic [BCD_W:0] t;

  always_comb begin
    t = {1'b0, a} + {1'b0, b} + {{BCD_W{1'b0}}, ci};
    if (t > {1'b0, BCD_MAX}) begin
      s  = BCD_W'(t - 5'd10);
      co = 1'b1;
    end else begin
      s  = t[BCD_W-1:0];
      co = 1'b0;
    end
  end

endmodule

// File: rtl/bcd_serial_adder.sv
// Multi-digit packed-BCD adder, one digit per clock, least-significant first.
//   Clock  : rising-edge clock
//   Resetn : asynchronous active-low reset
//   bus    : start/A/B/cin request in; busy/done/sum/cout/error out
// An accepted request with any non-decimal operand digit skips the add
// phase and reports error with a zero result.
module bcd_serial_adder
  import bcd_pkg::*;
#(
  parameter int unsigned NDIGITS = 4
) (
  input  logic              Clock,
  input  logic              Resetn,
  bcd_serial_adder_if.slave bus
);

  localparam int unsigned W    = BCD_W * NDIGITS;
  localparam int unsigned IdxW = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;

  state_e          state_q, state_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    b_q, b_d;
  logic [W-1:0]    sum_q, sum_d;
  logic            carry_q, carry_d;
  logic            cout_q, cout_d;
  logic            error_q, error_d;
  logic [IdxW-1:0] idx_q, idx_d;

  logic             operand_bad;
  logic [BCD_W-1:0] a_dig, b_dig, s_dig;
  logic             co_dig;
  logic             last_digit;

  always_comb begin
    operand_bad = 1'b0;
    for (int unsigned i = 0; i < NDIGITS; i++) begin
      if (digit_invalid(bus.A[BCD_W*i +: BCD_W]) || digit_invalid(bus.B[BCD_W*i +: BCD_W])) begin
        operand_bad = 1'b1;
      end
    end
  end

  // Digit select by index; constant part-selects keep the mux width-clean.
  always_comb begin
    a_dig = '0;
    b_dig = '0;
    for (int unsigned i = 0; i < NDIGITS; i++) begin
      if (idx_q == IdxW'(i)) begin
        a_dig = a_q[BCD_W*i +: BCD_W];
        b_dig = b_q[BCD_W*i +: BCD_W];
      end
    end
  end

  bcd_digit_add u_digit (
    .a  (a_dig),
    .b  (b_dig),
    .ci (carry_q),
    .s  (s_dig),
    .co (co_dig)
  );

  assign last_digit = (idx_q == IdxW'(NDIGITS - 1));

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    error_d = error_q;
    idx_d   = idx_q;

    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          a_d     = bus.A;
          b_d     = bus.B;
          carry_d = bus.cin;
          idx_d   = '0;
          sum_d   = '0;
          cout_d  = 1'b0;
          if (operand_bad) begin
            error_d = 1'b1;
            state_d = StDone;
          end else begin
            error_d = 1'b0;
            state_d = StAdd;
          end
        end
      end
      StAdd: begin
        for (int unsigned i = 0; i < NDIGITS; i++) begin
          if (idx_q == IdxW'(i)) begin
            sum_d[BCD_W*i +: BCD_W] = s_dig;
          end
        end
        carry_d = co_dig;
        idx_d   = idx_q + 1'b1;
        if (last_digit) begin
          cout_d  = co_dig;
          state_d = StDone;
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      error_q <= 1'b0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      error_q <= error_d;
      idx_q   <= idx_d;
    end
  end

  assign bus.busy  = (state_q == StAdd);
  assign bus.done  = (state_q == StDone);
  assign bus.sum   = sum_q;
  assign bus.cout  = cout_q;
  assign bus.error = error_q;

endmodule

// File: tb/tb_bcd_serial_adder.sv
// Scoreboard bench for bcd_serial_adder: a 4-digit and a 1-digit instance.
// Stimulus pushes expected results; per-instance monitors pop on done.
module tb_bcd_serial_adder;

  logic clk;
  logic rst_n;

  typedef struct {
    logic [15:0] sum;
    logic        cout;
    logic        err;
  } exp_t;

  exp_t q4[$];
  exp_t q1[$];
  exp_t m4_e;
  exp_t m1_e;

  int checks = 0;
  int errors = 0;

  bcd_serial_adder_if #(.NDIGITS(4)) if4 ();
  bcd_serial_adder_if #(.NDIGITS(1)) if1 ();

  bcd_serial_adder #(.NDIGITS(4)) u_dut4 (
    .Clock  (clk),
    .Resetn (rst_n),
    .bus    (if4.slave)
  );

  bcd_serial_adder #(.NDIGITS(1)) u_dut1 (
    .Clock  (clk),
    .Resetn (rst_n),
    .bus    (if1.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitors: compare every done pulse against the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && if4.done) begin
      if (q4.size() == 0) begin
        chk("dut4 unexpected done", 32'd1, 32'd0);
      end else begin
        m4_e = q4.pop_front();
        chk("dut4 sum", {16'd0, if4.sum}, {16'd0, m4_e.sum});
        chk("dut4 cout", {31'd0, if4.cout}, {31'd0, m4_e.cout});
        chk("dut4 error", {31'd0, if4.error}, {31'd0, m4_e.err});
      end
    end
    if (rst_n && if1.done) begin
      if (q1.size() == 0) begin
        chk("dut1 unexpected done", 32'd1, 32'd0);
      end else begin
        m1_e = q1.pop_front();
        chk("dut1 sum", {28'd0, if1.sum}, {16'd0, m1_e.sum});
        chk("dut1 cout", {31'd0, if1.cout}, {31'd0, m1_e.cout});
        chk("dut1 error", {31'd0, if1.error}, {31'd0, m1_e.err});
      end
    end
  end

  // One request; checks latency to done and number of busy cycles.
  task automatic run(input bit one, input logic [15:0] a, input logic [15:0] b,
                     input logic ci, input logic [15:0] es, input logic ec,
                     input logic ee, input string name);
    exp_t e;
    int   k;
    int   bc;
    int   n;
    bit   seen;
    n      = one ? 1 : 4;
    e.sum  = es;
    e.cout = ec;
    e.err  = ee;
    @(negedge clk);
    if (one) begin
      if1.A = a[3:0]; if1.B = b[3:0]; if1.cin = ci; if1.start = 1'b1;
      q1.push_back(e);
    end else begin
      if4.A = a; if4.B = b; if4.cin = ci; if4.start = 1'b1;
      q4.push_back(e);
    end
    @(posedge clk);
    #1;
    if (one) if1.start = 1'b0;
    else if4.start = 1'b0;
    k = 0; bc = 0; seen = 1'b0;
    while (!seen && k < 40) begin
      @(negedge clk);
      k++;
      if (one ? if1.busy : if4.busy) bc++;
      if (one ? if1.done : if4.done) seen = 1'b1;
    end
    chk({name, " latency"}, k, ee ? 1 : n + 1);
    chk({name, " busy cycles"}, bc, ee ? 0 : n);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    exp_t e;
    int   dcount;
    int   dn;
    int   cyc;
    int   t[3];

    rst_n = 1'b0;
    if4.start = 1'b0; if4.A = '0; if4.B = '0; if4.cin = 1'b0;
    if1.start = 1'b0; if1.A = '0; if1.B = '0; if1.cin = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset busy", {31'd0, if4.busy}, 32'd0);
    chk("reset done", {31'd0, if4.done}, 32'd0);
    chk("reset sum", {16'd0, if4.sum}, 32'd0);
    chk("reset cout", {31'd0, if4.cout}, 32'd0);
    chk("reset error", {31'd0, if4.error}, 32'd0);
    chk("reset dut1 sum", {28'd0, if1.sum}, 32'd0);
    rst_n = 1'b1;

    run(1'b0, 16'h1234, 16'h5678, 1'b0, 16'h6912, 1'b0, 1'b0, "1234+5678");
    run(1'b0, 16'h9999, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, "9999+0001");
    run(1'b0, 16'h9999, 16'h9999, 1'b1, 16'h9999, 1'b1, 1'b0, "9999+9999+1");
    run(1'b0, 16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 1'b0, "0+0+1");
    run(1'b0, 16'h12A4, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b1, "bad A");
    run(1'b0, 16'h0001, 16'hF000, 1'b1, 16'h0000, 1'b0, 1'b1, "bad B");
    run(1'b0, 16'h0456, 16'h0789, 1'b0, 16'h1245, 1'b0, 1'b0, "0456+0789");

    // start pulsed mid-operation must be ignored
    e.sum = 16'h6912; e.cout = 1'b0; e.err = 1'b0;
    @(negedge clk);
    if4.A = 16'h1234; if4.B = 16'h5678; if4.cin = 1'b0; if4.start = 1'b1;
    q4.push_back(e);
    @(posedge clk);
    #1 if4.start = 1'b0;
    repeat (2) @(negedge clk);
    if4.A = 16'h1111; if4.B = 16'h2222; if4.start = 1'b1;
    @(negedge clk);
    if4.start = 1'b0;
    dcount = 0;
    repeat (10) begin
      @(negedge clk);
      if (if4.done) dcount++;
    end
    chk("ignored start done pulses", dcount, 1);

    // asynchronous reset mid-add (idx=2)
    @(negedge clk);
    if4.A = 16'h1234; if4.B = 16'h5678; if4.cin = 1'b0; if4.start = 1'b1;
    @(posedge clk);
    #1 if4.start = 1'b0;
    repeat (3) @(negedge clk);
    chk("busy before reset", {31'd0, if4.busy}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async reset busy", {31'd0, if4.busy}, 32'd0);
    chk("async reset done", {31'd0, if4.done}, 32'd0);
    chk("async reset sum", {16'd0, if4.sum}, 32'd0);
    chk("async reset cout", {31'd0, if4.cout}, 32'd0);
    chk("async reset error", {31'd0, if4.error}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run(1'b0, 16'h0005, 16'h0005, 1'b0, 16'h0010, 1'b0, 1'b0, "0005+0005");

    // single-digit instance
    run(1'b1, 16'h0007, 16'h0008, 1'b0, 16'h0005, 1'b1, 1'b0, "dut1 7+8");
    run(1'b1, 16'h0009, 16'h0009, 1'b1, 16'h0009, 1'b1, 1'b0, "dut1 9+9+1");

    // start held high: back-to-back operations
    e.sum = 16'h0005; e.cout = 1'b1; e.err = 1'b0;
    t[0] = 0; t[1] = 0; t[2] = 0;
    @(negedge clk);
    if1.A = 4'h7; if1.B = 4'h8; if1.cin = 1'b0; if1.start = 1'b1;
    repeat (3) q1.push_back(e);
    dn = 0; cyc = 0;
    while (dn < 3 && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (if1.done) begin
        t[dn] = cyc;
        dn++;
      end
    end
    if1.start = 1'b0;
    chk("b2b done pulses", dn, 3);
    chk("b2b gap 1", t[1] - t[0], 3);
    chk("b2b gap 2", t[2] - t[1], 3);

    repeat (6) @(negedge clk);
    chk("dut4 scoreboard drained", q4.size(), 0);
    chk("dut1 scoreboard drained", q1.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
